button_debouncer: RTL and testbench
===================================

BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 The block SHALL have parameter N_BUTTONS, default 3: number of independent button channels.
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 500000: stability window in clk cycles (10 ms at 50 MHz); legal range 2..2^24.
REQ-003 The block SHALL have port clk, input, 1 bit: single system clock; all logic rising-edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port buttons_raw, input, N_BUTTONS bits: asynchronous active-low board keys.
REQ-006 The block SHALL have port buttons_clean, output, N_BUTTONS bits: debounced active-low levels; this is the direct feed to the Nios buttons PIO export.
REQ-007 The block SHALL have port press_pulse, output, N_BUTTONS bits: one-cycle high per debounced press (1->0).
REQ-008 The block SHALL have port release_pulse, output, N_BUTTONS bits: one-cycle high per debounced release (0->1).

Function
REQ-009 Each raw bit SHALL pass through a 2-flop synchronizer, reset value 1; only the synchronized bit (sync) feeds later logic.
REQ-010 Each channel SHALL run an independent FSM with states RELEASED, CHECK_PRESS, PRESSED and CHECK_RELEASE, plus a counter of width clog2(DEBOUNCE_CYCLES).
REQ-011 In RELEASED, sync=0 SHALL cause a move to CHECK_PRESS with the counter cleared; in PRESSED, sync=1 SHALL cause a move to CHECK_RELEASE with the counter cleared.
REQ-012 In CHECK_*, the counter SHALL increment each cycle sync holds the new value; any reversion SHALL return the FSM to the prior stable state with the counter cleared and no output change.
REQ-013 When the counter reaches DEBOUNCE_CYCLES-1 with sync still at the new value, the FSM SHALL enter the new stable state, and on the same edge buttons_clean SHALL toggle and the matching pulse SHALL assert for exactly one cycle.
REQ-014 Latency SHALL be: buttons_clean changes exactly 2+DEBOUNCE_CYCLES cycles after a raw edge that stays stable; glitches shorter than DEBOUNCE_CYCLES cycles SHALL produce no output activity.
REQ-015 The counter SHALL never wrap; it saturates only by leaving the CHECK state.
REQ-016 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL produce simultaneous pulses.
REQ-017 press_pulse and release_pulse of one channel SHALL never be high in the same cycle.

Reset
REQ-018 Reset SHALL put every FSM in RELEASED, clear counters, and drive buttons_clean to all ones and both pulse vectors to zero, asynchronously.
REQ-019 On reset deassertion with a key held, the press SHALL be reported normally after 2+DEBOUNCE_CYCLES cycles; reset mid-CHECK SHALL discard the partial count.

Configuration
REQ-020 The macro BTN_PRESS_COUNT_EN SHALL gate the press-counter feature.
REQ-021 With BTN_PRESS_COUNT_EN defined, the block SHALL add input count_clr (1 bit) and output press_count (N_BUTTONS*8 bits): per-channel 8-bit counters that increment on press_pulse and wrap 255->0. count_clr SHALL zero all counters synchronously and take priority over a coincident increment. Reset SHALL set the counters to 0.
REQ-022 With BTN_PRESS_COUNT_EN undefined, the block SHALL contain no count_clr or press_count ports and no counter logic.

Structure
REQ-023 Package btn_pkg SHALL hold the FSM state enum typedef (btn_state_t) and the constants SYNC_STAGES=2 and PRESS_CNT_W=8.
REQ-024 Sub-module btn_channel SHALL implement the synchronizer, FSM and counter for one channel; the top module SHALL generate N_BUTTONS instances.

Verification
Benches SHALL use DEBOUNCE_CYCLES=4.
REQ-025 Reset test: assert reset with raw=3'b000 -> clean=3'b111 and pulses=0 during reset; after release, clean=3'b000 at cycle 6, with press_pulse=3'b111 for one cycle.
REQ-026 Clean press test: raw[0] 1->0, held -> clean[0]=0 and press_pulse[0]=1 exactly 6 cycles later; other bits unchanged.
REQ-027 Glitch rejection test: raw[1] low for 3 cycles then high -> no change on clean or any pulse for 20 cycles.
REQ-028 Bounce test: raw[2] toggles 0/1/0/1 every 2 cycles, then holds 0 -> a single press_pulse[2], 6 cycles after the final edge.
REQ-029 Release and independence test: channel 0 released while channel 1 is pressed in the same cycle -> release_pulse[0] and press_pulse[1] are high in the same cycle.
REQ-030 Count test (BTN_PRESS_COUNT_EN defined): 257 presses on channel 0 -> press_count[7:0]=1; count_clr coincident with a press -> counter reads 0.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared types and constants for the button debouncer.
package btn_pkg;

  localparam int SYNC_STAGES = 2;
  localparam int PRESS_CNT_W = 8;

  typedef enum logic [1:0] {
    RELEASED,
    CHECK_PRESS,
    PRESSED,
    CHECK_RELEASE
  } btn_state_t;

endpackage

// File: rtl/btn_channel.sv
// One debounced key: 2-flop synchronizer, four-state stability FSM and window counter.
module btn_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic clean,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   sync;
  btn_state_t             state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next, cnt_inc;
  logic                   clean_reg, clean_next;
  logic                   press_reg, press_next;
  logic                   release_reg, release_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_reg <= '1;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw};
    end
  end

  assign sync    = sync_reg[SYNC_STAGES-1];
  assign cnt_inc = cnt_reg + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= RELEASED;
      cnt_reg     <= '0;
      clean_reg   <= 1'b1;
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      clean_reg   <= clean_next;
      press_reg   <= press_next;
      release_reg <= release_next;
    end
  end

  // The detecting cycle counts as the first stable cycle, so the window
  // closes when the incremented count reaches DEBOUNCE_CYCLES-1.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    clean_next   = clean_reg;
    press_next   = 1'b0;
    release_next = 1'b0;
    case (state_reg)
      RELEASED: begin
        if (!sync) begin
          state_next = CHECK_PRESS;
          cnt_next   = '0;
        end
      end
      CHECK_PRESS: begin
        if (sync) begin
          state_next = RELEASED;
          cnt_next   = '0;
        end else if (cnt_inc == LAST) begin
          state_next = PRESSED;
          cnt_next   = '0;
          clean_next = 1'b0;
          press_next = 1'b1;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      PRESSED: begin
        if (sync) begin
          state_next = CHECK_RELEASE;
          cnt_next   = '0;
        end
      end
      CHECK_RELEASE: begin
        if (!sync) begin
          state_next = PRESSED;
          cnt_next   = '0;
        end else if (cnt_inc == LAST) begin
          state_next   = RELEASED;
          cnt_next     = '0;
          clean_next   = 1'b1;
          release_next = 1'b1;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      default: begin
        state_next = RELEASED;
        cnt_next   = '0;
      end
    endcase
  end

  assign clean         = clean_reg;
  assign press_pulse   = press_reg;
  assign release_pulse = release_reg;

endmodule

// File: rtl/button_debouncer.sv
// N-channel active-low key debouncer with press/release pulses.
// Optional per-channel press counters are built when BTN_PRESS_COUNT_EN is defined.
module button_debouncer
  import btn_pkg::*;
#(
  parameter int N_BUTTONS       = 3,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                             clk,
  input  logic                             reset,
`ifdef BTN_PRESS_COUNT_EN
  input  logic                             count_clr,
  output logic [N_BUTTONS*PRESS_CNT_W-1:0] press_count,
`endif
  input  logic [N_BUTTONS-1:0]             buttons_raw,
  output logic [N_BUTTONS-1:0]             buttons_clean,
  output logic [N_BUTTONS-1:0]             press_pulse,
  output logic [N_BUTTONS-1:0]             release_pulse
);

  genvar gi;

  generate
    for (gi = 0; gi < N_BUTTONS; gi++) begin : g_chan
      btn_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_chan (
        .clk          (clk),
        .reset        (reset),
        .raw          (buttons_raw[gi]),
        .clean        (buttons_clean[gi]),
        .press_pulse  (press_pulse[gi]),
        .release_pulse(release_pulse[gi])
      );
    end
  endgenerate

`ifdef BTN_PRESS_COUNT_EN
  // Clear wins over a coincident press; counters wrap naturally at 8 bits.
  generate
    for (gi = 0; gi < N_BUTTONS; gi++) begin : g_cnt
      logic [PRESS_CNT_W-1:0] cnt_reg;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cnt_reg <= '0;
        end else if (count_clr) begin
          cnt_reg <= '0;
        end else if (press_pulse[gi]) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end

      assign press_count[gi*PRESS_CNT_W +: PRESS_CNT_W] = cnt_reg;
    end
  endgenerate
`else
  // Press counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer (DEBOUNCE_CYCLES=4); covers BTN_PRESS_COUNT_EN when defined.
module tb_button_debouncer;

  localparam int N = 3;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] buttons_raw = '1;
  logic [N-1:0] buttons_clean;
  logic [N-1:0] press_pulse;
  logic [N-1:0] release_pulse;
`ifdef BTN_PRESS_COUNT_EN
  logic         count_clr = 1'b0;
  logic [N*8-1:0] press_count;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: a key's output flips once the synchronized level has
  // differed from the current output for D consecutive cycles.
  logic [N-1:0] m_s1, m_s2, m_clean, m_press, m_rel;
  int           m_run [N];
  int           m_cnt [N];

  typedef struct {
    logic [2:0] raw;
    int         cycles;
    logic [2:0] clean;
    logic [2:0] press;
    logic [2:0] rel;
  } vec_t;

  vec_t tbl [20];

  button_debouncer #(
    .N_BUTTONS      (N),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk          (clk),
    .reset        (reset),
`ifdef BTN_PRESS_COUNT_EN
    .count_clr    (count_clr),
    .press_count  (press_count),
`endif
    .buttons_raw  (buttons_raw),
    .buttons_clean(buttons_clean),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_s1    = '1;
    m_s2    = '1;
    m_clean = '1;
    m_press = '0;
    m_rel   = '0;
    for (int i = 0; i < N; i++) begin
      m_run[i] = 0;
      m_cnt[i] = 0;
    end
  endtask

  task automatic model_edge();
    logic [N-1:0] s;
    s    = m_s2;
    m_s2 = m_s1;
    m_s1 = buttons_raw;
`ifdef BTN_PRESS_COUNT_EN
    for (int i = 0; i < N; i++) begin
      if (count_clr) m_cnt[i] = 0;
      else if (m_press[i]) m_cnt[i] = (m_cnt[i] + 1) % 256;
    end
`endif
    m_press = '0;
    m_rel   = '0;
    for (int i = 0; i < N; i++) begin
      if (s[i] != m_clean[i]) begin
        m_run[i]++;
        if (m_run[i] == D) begin
          m_clean[i] = s[i];
          m_run[i]   = 0;
          if (s[i] == 1'b0) m_press[i] = 1'b1;
          else m_rel[i] = 1'b1;
        end
      end else begin
        m_run[i] = 0;
      end
    end
  endtask

  task automatic check_vec(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_byte(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    check_vec("model_clean", buttons_clean, m_clean);
    check_vec("model_press", press_pulse, m_press);
    check_vec("model_release", release_pulse, m_rel);
    check_vec("press_and_release_exclusive", press_pulse & release_pulse, '0);
`ifdef BTN_PRESS_COUNT_EN
    for (int i = 0; i < N; i++) begin
      check_byte("model_press_count", press_count[i*8 +: 8], 8'(m_cnt[i]));
    end
`endif
  endtask

  task automatic step();
    @(posedge clk);
    if (!reset) model_edge();
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1;
    check_vec("reset_clean", buttons_clean, 3'b111);
    check_vec("reset_press", press_pulse, 3'b000);
    check_vec("reset_release", release_pulse, 3'b000);
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{3'b000, 5,  3'b111, 3'b000, 3'b000};
    tbl[1]  = '{3'b000, 1,  3'b000, 3'b111, 3'b000};
    tbl[2]  = '{3'b000, 1,  3'b000, 3'b000, 3'b000};
    tbl[3]  = '{3'b111, 6,  3'b111, 3'b000, 3'b111};
    tbl[4]  = '{3'b111, 1,  3'b111, 3'b000, 3'b000};
    tbl[5]  = '{3'b110, 5,  3'b111, 3'b000, 3'b000};
    tbl[6]  = '{3'b110, 1,  3'b110, 3'b001, 3'b000};
    tbl[7]  = '{3'b110, 1,  3'b110, 3'b000, 3'b000};
    tbl[8]  = '{3'b100, 3,  3'b110, 3'b000, 3'b000};
    tbl[9]  = '{3'b110, 20, 3'b110, 3'b000, 3'b000};
    tbl[10] = '{3'b010, 2,  3'b110, 3'b000, 3'b000};
    tbl[11] = '{3'b110, 2,  3'b110, 3'b000, 3'b000};
    tbl[12] = '{3'b010, 2,  3'b110, 3'b000, 3'b000};
    tbl[13] = '{3'b110, 2,  3'b110, 3'b000, 3'b000};
    tbl[14] = '{3'b010, 5,  3'b110, 3'b000, 3'b000};
    tbl[15] = '{3'b010, 1,  3'b010, 3'b100, 3'b000};
    tbl[16] = '{3'b010, 1,  3'b010, 3'b000, 3'b000};
    tbl[17] = '{3'b001, 5,  3'b010, 3'b000, 3'b000};
    tbl[18] = '{3'b001, 1,  3'b001, 3'b010, 3'b001};
    tbl[19] = '{3'b001, 1,  3'b001, 3'b000, 3'b000};

    // Reset with all keys held, then the directed table.
    buttons_raw = 3'b000;
    @(posedge clk);
    #1;
    do_reset();
    for (int v = 0; v < 20; v++) begin
      buttons_raw = tbl[v].raw;
      for (int c = 0; c < tbl[v].cycles; c++) step();
      check_vec("tbl_clean", buttons_clean, tbl[v].clean);
      check_vec("tbl_press", press_pulse, tbl[v].press);
      check_vec("tbl_release", release_pulse, tbl[v].rel);
      $display("vector %0d raw=%b cycles=%0d clean=%b press=%b release=%b",
               v, tbl[v].raw, tbl[v].cycles, buttons_clean, press_pulse, release_pulse);
    end

    // Randomized bursts of mixed short glitches and stable holds, with occasional resets.
    for (int b = 0; b < 400; b++) begin
      int hold;
      hold = $urandom_range(1, 10);
      buttons_raw = 3'($urandom);
`ifdef BTN_PRESS_COUNT_EN
      count_clr = ($urandom_range(0, 15) == 0);
`endif
      if ($urandom_range(0, 39) == 0) do_reset();
      for (int c = 0; c < hold; c++) step();
      $display("burst %0d raw=%b hold=%0d clean=%b", b, buttons_raw, hold, buttons_clean);
    end

`ifdef BTN_PRESS_COUNT_EN
    count_clr   = 1'b0;
    buttons_raw = 3'b111;
    do_reset();
    for (int k = 0; k < 257; k++) begin
      buttons_raw = 3'b110;
      for (int c = 0; c < 7; c++) step();
      buttons_raw = 3'b111;
      for (int c = 0; c < 7; c++) step();
    end
    check_byte("count_257_presses", press_count[7:0], 8'd1);
    $display("count after 257 presses = %0d", press_count[7:0]);
    buttons_raw = 3'b110;
    for (int c = 0; c < 6; c++) step();
    check_vec("clr_case_press_visible", press_pulse, 3'b001);
    count_clr = 1'b1;
    step();
    count_clr = 1'b0;
    check_byte("count_clr_priority", press_count[7:0], 8'd0);
    $display("count after coincident clear = %0d", press_count[7:0]);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
